// File: rtl/victim_wb_buffer_pkg.sv
// Shared write-back buffer definitions for the dcache / victim cache path.
package victim_wb_buffer_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int VICTIM_ADDR_BITS  = 28;
  localparam int WB_DEPTH          = 4;
  localparam int WB_PTR_BITS       = $clog2(WB_DEPTH);

  typedef struct packed {
    logic                         valid;
    logic [VICTIM_ADDR_BITS-1:0]  addr;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/victim_wb_buffer_match.sv
// Parallel address compare against all buffer entries; reports a one-hot
// match vector and the index of the youngest matching entry (closest to tail).
module wb_addr_match #(
  parameter int ADDR_W = 28,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_entry_addr,
  input  logic [PTR_W-1:0]             i_head,
  output logic [DEPTH-1:0]             o_match,
  output logic [PTR_W-1:0]             o_sel
);

  logic [PTR_W-1:0] w_idx;

  // Compare the address against every valid entry in parallel.
  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_valid[i] & (i_entry_addr[i] == i_addr);
    end
  end

  // Walk oldest to youngest from head; the last match seen is the youngest.
  always_comb begin
    o_sel = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PTR_W'(k);
      if (o_match[w_idx]) o_sel = w_idx;
    end
  end

endmodule

// File: rtl/victim_wb_buffer.sv
// Write-back buffer behind the victim cache: queues dirty lines, drains them
// to memory over req/ack, forwards still-queued lines, and supports flush.
module victim_wb_buffer #(
  parameter int DCACHE_LINE_WIDTH = victim_wb_buffer_pkg::DCACHE_LINE_WIDTH,
  parameter int VICTIM_ADDR_BITS  = victim_wb_buffer_pkg::VICTIM_ADDR_BITS,
  parameter int WB_DEPTH          = victim_wb_buffer_pkg::WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  output logic                         flush_done_o,
  input  logic                         evict_valid_i,
  input  logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
  output logic                         evict_ready_o,
  input  logic [VICTIM_ADDR_BITS-1:0]  lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [DCACHE_LINE_WIDTH-1:0] lookup_data_o,
  output logic                         mem_wr_req_o,
  output logic [VICTIM_ADDR_BITS-1:0]  mem_wr_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] mem_wr_data_o,
  input  logic                         mem_wr_ack_i
);

  import victim_wb_buffer_pkg::*;

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

  logic [WB_DEPTH-1:0]                       r_valid;
  logic [WB_DEPTH-1:0][VICTIM_ADDR_BITS-1:0] r_addr;
  logic [DCACHE_LINE_WIDTH-1:0]              r_data [WB_DEPTH];
  logic [PTR_W-1:0]                          r_head;
  logic [PTR_W-1:0]                          r_tail;
  logic [CNT_W-1:0]                          r_count;
  logic                                      r_flush_pending;
  wb_state_e                                 r_state;

  wb_state_e           w_state_nxt;
  logic                w_pop;
  logic                w_enq;
  logic                w_merge;
  logic                w_alloc;
  logic [WB_DEPTH-1:0] w_head_mask;
  logic [WB_DEPTH-1:0] w_lookup_match;
  logic [WB_DEPTH-1:0] w_merge_match;
  logic [PTR_W-1:0]    w_lookup_sel;
  logic [PTR_W-1:0]    w_merge_sel;

  // The head is frozen while its write is outstanding, so merges must skip it.
  assign w_head_mask = (r_state == WB_REQ) ? (WB_DEPTH'(1) << r_head) : '0;

  wb_addr_match #(.ADDR_W(VICTIM_ADDR_BITS), .DEPTH(WB_DEPTH), .PTR_W(PTR_W)) u_lookup_match (
    .i_addr       (lookup_addr_i),
    .i_valid      (r_valid),
    .i_entry_addr (r_addr),
    .i_head       (r_head),
    .o_match      (w_lookup_match),
    .o_sel        (w_lookup_sel)
  );

  wb_addr_match #(.ADDR_W(VICTIM_ADDR_BITS), .DEPTH(WB_DEPTH), .PTR_W(PTR_W)) u_merge_match (
    .i_addr       (evict_addr_i),
    .i_valid      (r_valid & ~w_head_mask),
    .i_entry_addr (r_addr),
    .i_head       (r_head),
    .o_match      (w_merge_match),
    .o_sel        (w_merge_sel)
  );

  assign evict_ready_o = (r_count < FULL_CNT) & ~r_flush_pending;
  assign w_enq         = evict_valid_i & evict_ready_o;
  assign w_merge       = w_enq & (|w_merge_match);
  assign w_alloc       = w_enq & ~(|w_merge_match);

  assign lookup_hit_o  = |w_lookup_match;
  assign lookup_data_o = lookup_hit_o ? r_data[w_lookup_sel] : '0;

  assign mem_wr_req_o  = (r_state == WB_REQ);
  assign mem_wr_addr_o = mem_wr_req_o ? r_addr[r_head] : '0;
  assign mem_wr_data_o = mem_wr_req_o ? r_data[r_head] : '0;

  assign flush_done_o  = r_flush_pending & (r_count == '0) & (r_state == WB_IDLE);

  // Drain FSM next state: request when anything is queued, pop on ack.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      WB_IDLE: if (r_count != '0) w_state_nxt = WB_REQ;
      WB_REQ: begin
        if (mem_wr_ack_i) begin
          w_pop       = 1'b1;
          w_state_nxt = WB_IDLE;
        end
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= WB_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Queue control: valid bits, pointers, occupancy and sticky flush request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      unique case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_flush_pending <= flush_i | (r_flush_pending & ~flush_done_o);
    end
  end

  // Entry payload: new lines land at tail, merges only rewrite data.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= evict_addr_i;
      r_data[r_tail] <= evict_data_i;
    end else if (w_merge) begin
      r_data[w_merge_sel] <= evict_data_i;
    end
  end

endmodule
